dcpu16_barb: RTL and testbench
==============================

DCPU16_BARB -- requirements
Module: dcpu16_barb

Interface
REQ-001 SHALL have ports: clk  in  1  system clock, all state on rising edge.
REQ-002 SHALL have: rst  in  1  reset, synchronous, active-high.
REQ-003 SHALL have F-bus slave: f_adr in 16 address; f_stb in 1 strobe; f_wre in 1 write enable; f_dto in 16 write data; f_dti out 16 read data; f_ack out 1 acknowledge.
REQ-004 SHALL have G-bus slave: g_adr in 16; g_stb in 1; g_wre in 1; g_dto in 16; g_dti out 16; g_ack out 1 (same meanings as F-bus).
REQ-005 SHALL have memory master: m_adr out 16; m_stb out 1; m_wre out 1; m_dto out 16 write data; m_dti in 16 read data; m_ack in 1 single-cycle memory acknowledge.
REQ-006 One clock domain; reset synchronous active-high, as already decided.

Function
REQ-007 SHALL implement FSM states IDLE, GACC, FACC, RESP.
REQ-008 IDLE: sample f_stb/g_stb; g_stb=1 -> GACC; else f_stb=1 -> FACC; neither -> stay IDLE.
REQ-009 On IDLE exit SHALL latch pending flags pf=f_stb, pg=g_stb and the address/wre/write-data of both buses.
REQ-010 GACC/FACC: m_stb=1 with latched adr/wre/dto of that bus, held constant until m_ack=1.
REQ-011 On m_ack in GACC SHALL capture m_dti into g read buffer; then -> FACC if pf, else -> RESP.
REQ-012 On m_ack in FACC SHALL capture m_dti into f read buffer; then -> RESP.
REQ-013 m_stb SHALL drop for at least the cycle following each m_ack (registered master outputs); back-to-back G then F costs one idle master cycle.
REQ-014 RESP (exactly one cycle): f_ack=pf, g_ack=pg simultaneously; f_dti/g_dti present buffered data; -> IDLE.
REQ-015 Acks SHALL never be asserted outside RESP and SHALL be single-cycle pulses; a bus with strobe low at IDLE sampling is never acked for that round.
REQ-016 Simultaneous requests SHALL be served G first, then F, acks co-released in one RESP cycle (the consuming pipeline stalls until both stb/ack pairs match).
REQ-017 Minimum latency with zero-wait memory (m_ack in first m_stb cycle): request sampled cycle 0, m_stb cycle 1, ack cycle 2; with both buses: ack cycle 4.
REQ-018 Write transfers SHALL ack identically; read buffer contents for write transfers are don't-care but SHALL not corrupt the other bus's buffer.
REQ-019 Strobe changes during GACC/FACC/RESP SHALL be ignored; new requests are sampled only in IDLE (the cycle after RESP earliest).
REQ-020 m_ack while m_stb=0 SHALL be ignored.
REQ-021 f_dti/g_dti SHALL hold last captured values outside RESP.

Reset
REQ-022 On rst: state IDLE, m_stb=0, m_wre=0, m_adr=0, m_dto=0, f_ack=0, g_ack=0, f_dti=0, g_dti=0, pf=pg=0.
REQ-023 rst mid-transfer SHALL abort: m_stb=0 and no ack the following cycle; a late m_ack after reset is ignored per REQ-020.

Verification
REQ-024 Single G read: g_stb=1, g_adr=0x1234, memory returns 0xBEEF zero-wait -> m_adr=0x1234 m_stb cycle 1, g_ack=1 g_dti=0xBEEF cycle 2, f_ack=0.
REQ-025 Simultaneous: g_adr=0x0010, f_adr=0x0020 read, memory 0x1111/0x2222 -> master order 0x0010 then 0x0020, f_ack and g_ack both 1 in same single cycle with g_dti=0x1111, f_dti=0x2222.
REQ-026 F write with 3-wait memory: f_stb=1 f_wre=1 f_adr=0xFFFF f_dto=0x00A5 -> m_wre=1 m_dto=0x00A5 held 4 cycles until m_ack, f_ack one cycle later, single pulse.
REQ-027 Reset during GACC (m_stb=1, no m_ack) -> next cycle m_stb=0, acks 0; subsequent stray m_ack produces no ack.
REQ-028 Back-to-back: strobes held high after RESP -> new round starts in IDLE next cycle, no ack duplicated, m_stb gap per REQ-013.

Source files
------------

// File: rtl/dcpu16_barb_if.sv
// Simple strobe/acknowledge bus shared by the F, G and memory ports.
// The master drives address, strobe, write enable and write data;
// the slave returns read data and a single-cycle acknowledge.
interface dcpu16_barb_if;
  logic [15:0] adr;
  logic        stb;
  logic        wre;
  logic [15:0] dto;
  logic [15:0] dti;
  logic        ack;

  modport master (output adr, output stb, output wre, output dto,
                  input  dti, input  ack);
  modport slave  (input  adr, input  stb, input  wre, input  dto,
                  output dti, output ack);
endinterface

// File: rtl/dcpu16_barb.sv
// Two-port arbiter in front of a single memory master.
// A round starts in IDLE by sampling both slave strobes; G is served before F,
// then both requesters are acknowledged together in one RESP cycle.
module dcpu16_barb (
  input  logic                 clk,
  input  logic                 rst,
  dcpu16_barb_if.slave         f,
  dcpu16_barb_if.slave         g,
  dcpu16_barb_if.master        m
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 16;

  typedef enum logic [1:0] {IDLE, GACC, FACC, RESP} state_t;

  state_t        state_q, state_d;
  logic          pf_q, pf_d;
  logic          pg_q, pg_d;
  logic [AW-1:0] fa_q, fa_d;
  logic [AW-1:0] ga_q, ga_d;
  logic          fw_q, fw_d;
  logic          gw_q, gw_d;
  logic [DW-1:0] fd_q, fd_d;
  logic [DW-1:0] gd_q, gd_d;
  logic [AW-1:0] madr_q, madr_d;
  logic          mstb_q, mstb_d;
  logic          mwre_q, mwre_d;
  logic [DW-1:0] mdto_q, mdto_d;
  logic          fack_q, fack_d;
  logic          gack_q, gack_d;
  logic [DW-1:0] fbuf_q, fbuf_d;
  logic [DW-1:0] gbuf_q, gbuf_d;

  assign m.adr = madr_q;
  assign m.stb = mstb_q;
  assign m.wre = mwre_q;
  assign m.dto = mdto_q;
  assign f.ack = fack_q;
  assign g.ack = gack_q;
  assign f.dti = fbuf_q;
  assign g.dti = gbuf_q;

  // Next-state and next-output decode; every master/ack output is registered.
  always_comb begin
    state_d = state_q;
    pf_d    = pf_q;
    pg_d    = pg_q;
    fa_d    = fa_q;
    ga_d    = ga_q;
    fw_d    = fw_q;
    gw_d    = gw_q;
    fd_d    = fd_q;
    gd_d    = gd_q;
    madr_d  = madr_q;
    mstb_d  = 1'b0;
    mwre_d  = mwre_q;
    mdto_d  = mdto_q;
    fack_d  = 1'b0;
    gack_d  = 1'b0;
    fbuf_d  = fbuf_q;
    gbuf_d  = gbuf_q;

    unique case (state_q)
      IDLE: begin
        if (g.stb || f.stb) begin
          pf_d = f.stb;
          pg_d = g.stb;
          fa_d = f.adr;
          fw_d = f.wre;
          fd_d = f.dto;
          ga_d = g.adr;
          gw_d = g.wre;
          gd_d = g.dto;
        end
        if (g.stb) begin
          state_d = GACC;
          mstb_d  = 1'b1;
          madr_d  = g.adr;
          mwre_d  = g.wre;
          mdto_d  = g.dto;
        end else if (f.stb) begin
          state_d = FACC;
          mstb_d  = 1'b1;
          madr_d  = f.adr;
          mwre_d  = f.wre;
          mdto_d  = f.dto;
        end
      end

      GACC: begin
        // An ack only counts against a strobe we are actually presenting.
        if (mstb_q && m.ack) begin
          gbuf_d = m.dti;
          if (pf_q) begin
            state_d = FACC;
          end else begin
            state_d = RESP;
            gack_d  = pg_q;
            fack_d  = pf_q;
          end
        end else begin
          mstb_d = 1'b1;
          madr_d = ga_q;
          mwre_d = gw_q;
          mdto_d = gd_q;
        end
      end

      FACC: begin
        // Entered from GACC with strobe low, which yields the mandatory gap cycle.
        if (mstb_q && m.ack) begin
          fbuf_d  = m.dti;
          state_d = RESP;
          fack_d  = pf_q;
          gack_d  = pg_q;
        end else begin
          mstb_d = 1'b1;
          madr_d = fa_q;
          mwre_d = fw_q;
          mdto_d = fd_q;
        end
      end

      RESP: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pf_q    <= 1'b0;
      pg_q    <= 1'b0;
      fa_q    <= '0;
      ga_q    <= '0;
      fw_q    <= 1'b0;
      gw_q    <= 1'b0;
      fd_q    <= '0;
      gd_q    <= '0;
      madr_q  <= '0;
      mstb_q  <= 1'b0;
      mwre_q  <= 1'b0;
      mdto_q  <= '0;
      fack_q  <= 1'b0;
      gack_q  <= 1'b0;
      fbuf_q  <= '0;
      gbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      pf_q    <= pf_d;
      pg_q    <= pg_d;
      fa_q    <= fa_d;
      ga_q    <= ga_d;
      fw_q    <= fw_d;
      gw_q    <= gw_d;
      fd_q    <= fd_d;
      gd_q    <= gd_d;
      madr_q  <= madr_d;
      mstb_q  <= mstb_d;
      mwre_q  <= mwre_d;
      mdto_q  <= mdto_d;
      fack_q  <= fack_d;
      gack_q  <= gack_d;
      fbuf_q  <= fbuf_d;
      gbuf_q  <= gbuf_d;
    end
  end

endmodule

// File: tb/tb_dcpu16_barb.sv
// Directed bench for dcpu16_barb: inputs change and outputs are sampled 1ns
// after each rising edge; the memory side is played by hand in each step.
module tb_dcpu16_barb;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;

  dcpu16_barb_if f_bus ();
  dcpu16_barb_if g_bus ();
  dcpu16_barb_if m_bus ();

  dcpu16_barb dut (
    .clk (clk),
    .rst (rst),
    .f   (f_bus),
    .g   (g_bus),
    .m   (m_bus)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk16(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  initial begin
    rst       = 1'b1;
    f_bus.stb = 1'b0; f_bus.wre = 1'b0; f_bus.adr = 16'h0; f_bus.dto = 16'h0;
    g_bus.stb = 1'b0; g_bus.wre = 1'b0; g_bus.adr = 16'h0; g_bus.dto = 16'h0;
    m_bus.ack = 1'b0; m_bus.dti = 16'h0;

    // Reset values
    step(); step();
    chk1 ("rst_mstb", m_bus.stb, 1'b0);
    chk1 ("rst_mwre", m_bus.wre, 1'b0);
    chk16("rst_madr", m_bus.adr, 16'h0000);
    chk16("rst_mdto", m_bus.dto, 16'h0000);
    chk1 ("rst_fack", f_bus.ack, 1'b0);
    chk1 ("rst_gack", g_bus.ack, 1'b0);
    chk16("rst_fdti", f_bus.dti, 16'h0000);
    chk16("rst_gdti", g_bus.dti, 16'h0000);
    rst = 1'b0;
    step();

    // Single G read, zero-wait memory
    g_bus.stb = 1'b1; g_bus.adr = 16'h1234; g_bus.wre = 1'b0;
    step();
    chk1 ("g1_mstb", m_bus.stb, 1'b1);
    chk16("g1_madr", m_bus.adr, 16'h1234);
    chk1 ("g1_mwre", m_bus.wre, 1'b0);
    chk1 ("g1_gack_early", g_bus.ack, 1'b0);
    m_bus.ack = 1'b1; m_bus.dti = 16'hBEEF;
    step();
    m_bus.ack = 1'b0;
    chk1 ("g1_gack", g_bus.ack, 1'b1);
    chk16("g1_gdti", g_bus.dti, 16'hBEEF);
    chk1 ("g1_fack", f_bus.ack, 1'b0);
    chk1 ("g1_mstb_drop", m_bus.stb, 1'b0);
    g_bus.stb = 1'b0;
    step();
    chk1 ("g1_gack_pulse", g_bus.ack, 1'b0);
    chk16("g1_gdti_hold", g_bus.dti, 16'hBEEF);

    // Simultaneous G and F reads: G first, then F, acks together
    g_bus.stb = 1'b1; g_bus.adr = 16'h0010;
    f_bus.stb = 1'b1; f_bus.adr = 16'h0020; f_bus.wre = 1'b0;
    step();
    chk1 ("s_mstb_g", m_bus.stb, 1'b1);
    chk16("s_madr_g", m_bus.adr, 16'h0010);
    m_bus.ack = 1'b1; m_bus.dti = 16'h1111;
    step();
    m_bus.ack = 1'b0; m_bus.dti = 16'h0000;
    chk1 ("s_gap_mstb", m_bus.stb, 1'b0);
    chk1 ("s_gap_gack", g_bus.ack, 1'b0);
    chk1 ("s_gap_fack", f_bus.ack, 1'b0);
    step();
    chk1 ("s_mstb_f", m_bus.stb, 1'b1);
    chk16("s_madr_f", m_bus.adr, 16'h0020);
    m_bus.ack = 1'b1; m_bus.dti = 16'h2222;
    step();
    m_bus.ack = 1'b0;
    chk1 ("s_gack", g_bus.ack, 1'b1);
    chk1 ("s_fack", f_bus.ack, 1'b1);
    chk16("s_gdti", g_bus.dti, 16'h1111);
    chk16("s_fdti", f_bus.dti, 16'h2222);
    g_bus.stb = 1'b0; f_bus.stb = 1'b0;
    step();
    chk1 ("s_gack_pulse", g_bus.ack, 1'b0);
    chk1 ("s_fack_pulse", f_bus.ack, 1'b0);

    // F write with three wait states
    f_bus.stb = 1'b1; f_bus.wre = 1'b1; f_bus.adr = 16'hFFFF; f_bus.dto = 16'h00A5;
    step();
    for (int i = 0; i < 3; i++) begin
      chk1 ("w_mstb", m_bus.stb, 1'b1);
      chk1 ("w_mwre", m_bus.wre, 1'b1);
      chk16("w_madr", m_bus.adr, 16'hFFFF);
      chk16("w_mdto", m_bus.dto, 16'h00A5);
      chk1 ("w_fack_wait", f_bus.ack, 1'b0);
      step();
    end
    chk1 ("w_mstb_4", m_bus.stb, 1'b1);
    chk16("w_mdto_4", m_bus.dto, 16'h00A5);
    m_bus.ack = 1'b1; m_bus.dti = 16'h5A5A;
    step();
    m_bus.ack = 1'b0;
    chk1 ("w_fack", f_bus.ack, 1'b1);
    chk1 ("w_gack", g_bus.ack, 1'b0);
    chk1 ("w_mstb_drop", m_bus.stb, 1'b0);
    chk16("w_gdti_kept", g_bus.dti, 16'h1111);
    f_bus.stb = 1'b0; f_bus.wre = 1'b0;
    step();
    chk1 ("w_fack_pulse", f_bus.ack, 1'b0);

    // Stray memory ack while idle
    m_bus.ack = 1'b1; m_bus.dti = 16'hDEAD;
    step(); step();
    chk1 ("stray_mstb", m_bus.stb, 1'b0);
    chk1 ("stray_fack", f_bus.ack, 1'b0);
    chk1 ("stray_gack", g_bus.ack, 1'b0);
    chk16("stray_gdti", g_bus.dti, 16'h1111);
    m_bus.ack = 1'b0;
    step();

    // Reset during GACC aborts the transfer
    g_bus.stb = 1'b1; g_bus.adr = 16'h4444; g_bus.wre = 1'b0;
    step();
    chk1 ("r_mstb_pre", m_bus.stb, 1'b1);
    rst = 1'b1; g_bus.stb = 1'b0;
    step();
    rst = 1'b0;
    chk1 ("r_mstb", m_bus.stb, 1'b0);
    chk1 ("r_gack", g_bus.ack, 1'b0);
    chk1 ("r_fack", f_bus.ack, 1'b0);
    chk16("r_gdti", g_bus.dti, 16'h0000);
    m_bus.ack = 1'b1; m_bus.dti = 16'h7777;
    step();
    m_bus.ack = 1'b0;
    chk1 ("r_late_gack", g_bus.ack, 1'b0);
    chk1 ("r_late_mstb", m_bus.stb, 1'b0);
    step();
    chk1 ("r_late_gack2", g_bus.ack, 1'b0);
    chk16("r_late_gdti", g_bus.dti, 16'h0000);

    // Back-to-back rounds with G strobe held high
    g_bus.stb = 1'b1; g_bus.adr = 16'h0100;
    step();
    chk1 ("b_mstb1", m_bus.stb, 1'b1);
    chk16("b_madr1", m_bus.adr, 16'h0100);
    m_bus.ack = 1'b1; m_bus.dti = 16'hAAAA;
    step();
    m_bus.ack = 1'b0;
    chk1 ("b_gack1", g_bus.ack, 1'b1);
    chk16("b_gdti1", g_bus.dti, 16'hAAAA);
    chk1 ("b_mstb_gap1", m_bus.stb, 1'b0);
    step();
    chk1 ("b_gack_idle", g_bus.ack, 1'b0);
    chk1 ("b_mstb_gap2", m_bus.stb, 1'b0);
    step();
    chk1 ("b_mstb2", m_bus.stb, 1'b1);
    chk16("b_madr2", m_bus.adr, 16'h0100);
    chk1 ("b_gack_nodup", g_bus.ack, 1'b0);
    m_bus.ack = 1'b1; m_bus.dti = 16'hBBBB;
    step();
    m_bus.ack = 1'b0;
    chk1 ("b_gack2", g_bus.ack, 1'b1);
    chk16("b_gdti2", g_bus.dti, 16'hBBBB);
    chk1 ("b_fack2", f_bus.ack, 1'b0);
    g_bus.stb = 1'b0;
    step();
    chk1 ("b_gack2_pulse", g_bus.ack, 1'b0);
    step();
    chk1 ("b_end_mstb", m_bus.stb, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
